// File: rtl/pll_loop_ctrl.sv
// pll_loop_ctrl: closed-loop step controller for the NCO/phase-detector PLL.
// Integrates the detector's error code over fixed windows. After each window
// it writes a corrected, saturated phase step back to the PLL, using a coarse
// gain during acquisition and a fine gain while tracking or locked.
module pll_loop_ctrl #(
    parameter int                    PHASE_BITS    = 32,
    parameter logic [PHASE_BITS-2:0] INITIAL_STEP  = '0,
    parameter int                    WINDOW_LEN    = 16,
    parameter int                    ACQ_WINDOWS   = 8,
    parameter int                    ACQ_SHIFT     = 8,
    parameter int                    TRK_SHIFT     = 4,
    parameter logic [PHASE_BITS-2:0] STEP_MIN      = {{(PHASE_BITS-2){1'b0}}, 1'b1},
    parameter logic [PHASE_BITS-2:0] STEP_MAX      = '1,
    parameter int                    LOCK_THRESH   = 2,
    parameter int                    LOCK_COUNT    = 4,
    parameter int                    UNLOCK_THRESH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [PHASE_BITS-2:0] i_nom_step,
    input  logic [1:0]            i_err,
    output logic [PHASE_BITS-2:0] o_step,
    output logic                  o_ld,
    output logic                  o_locked,
    output logic [2:0]            o_state
);

    localparam int STEP_W = PHASE_BITS - 1;
    localparam int WCW    = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
    localparam int NW     = $clog2(WINDOW_LEN) + 2;
    localparam int AW     = $clog2(ACQ_WINDOWS + 1);
    localparam int QW     = $clog2(LOCK_COUNT + 1);
    // Wide enough for step plus the largest shifted net without overflow.
    localparam int CW     = STEP_W + ACQ_SHIFT + $clog2(WINDOW_LEN) + 2;

    localparam logic signed [CW-1:0] MIN_EXT = $signed({{(CW-STEP_W){1'b0}}, STEP_MIN});
    localparam logic signed [CW-1:0] MAX_EXT = $signed({{(CW-STEP_W){1'b0}}, STEP_MAX});

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ACQUIRE = 3'd2,
        TRACK   = 3'd3,
        LOCKED  = 3'd4,
        UPDATE  = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    state_t                   ret_q, ret_d;      // mode that UPDATE returns to
    logic [WCW-1:0]           win_q, win_d;      // sample index within window
    logic signed [NW-1:0]     net_q, net_d;      // lag minus lead over window
    logic [AW-1:0]            acq_q, acq_d;      // completed acquisition windows
    logic [QW-1:0]            quiet_q, quiet_d;  // consecutive quiet windows
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     ld_q, ld_d;
    logic                     locked_q, locked_d;

    logic signed [NW-1:0]     delta;
    logic signed [CW-1:0]     step_ext, net_ext, sum_c;
    logic [STEP_W-1:0]        sat_c;
    int                       net_abs;

    // Next-state, window integration and step update arithmetic.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        win_d    = win_q;
        net_d    = net_q;
        acq_d    = acq_q;
        quiet_d  = quiet_q;
        step_d   = step_q;
        ld_d     = 1'b0;
        locked_d = locked_q;

        // Error code decode: lag pulls the step up, lead pulls it down.
        case (i_err)
            2'b01:   delta = {{(NW-1){1'b0}}, 1'b1};
            2'b11:   delta = '1;
            default: delta = '0;
        endcase

        step_ext = $signed({{(CW-STEP_W){1'b0}}, step_q});
        net_ext  = CW'(net_q);
        sum_c    = step_ext + ((ret_q == ACQUIRE) ? (net_ext <<< ACQ_SHIFT)
                                                  : (net_ext <<< TRK_SHIFT));
        if (sum_c < MIN_EXT)
            sat_c = STEP_MIN;
        else if (sum_c > MAX_EXT)
            sat_c = STEP_MAX;
        else
            sat_c = sum_c[STEP_W-1:0];

        net_abs = net_q[NW-1] ? -int'(net_q) : int'(net_q);

        if (!i_en) begin
            // Disable wins over everything, including a finishing window.
            state_d  = IDLE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = LOAD;
                LOAD: begin
                    step_d  = i_nom_step;
                    ld_d    = 1'b1;
                    state_d = ACQUIRE;
                    win_d   = '0;
                    net_d   = '0;
                    acq_d   = '0;
                    quiet_d = '0;
                end
                ACQUIRE, TRACK, LOCKED: begin
                    net_d = net_q + delta;
                    if (win_q == WCW'(WINDOW_LEN - 1)) begin
                        ret_d   = state_q;
                        state_d = UPDATE;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
                UPDATE: begin
                    step_d = sat_c;
                    ld_d   = 1'b1;
                    net_d  = '0;
                    win_d  = '0;
                    case (ret_q)
                        ACQUIRE: begin
                            acq_d = acq_q + 1'b1;
                            if (acq_d == AW'(ACQ_WINDOWS)) begin
                                state_d = TRACK;
                                quiet_d = '0;
                            end else begin
                                state_d = ACQUIRE;
                            end
                        end
                        TRACK: begin
                            quiet_d = (net_abs <= LOCK_THRESH) ? quiet_q + 1'b1 : '0;
                            if (quiet_d == QW'(LOCK_COUNT)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                state_d = TRACK;
                            end
                        end
                        default: begin
                            if (net_abs > UNLOCK_THRESH) begin
                                state_d  = TRACK;
                                locked_d = 1'b0;
                                quiet_d  = '0;
                            end else begin
                                state_d = LOCKED;
                            end
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset drops the load strobe at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ret_q    <= ACQUIRE;
            win_q    <= '0;
            net_q    <= '0;
            acq_q    <= '0;
            quiet_q  <= '0;
            step_q   <= INITIAL_STEP;
            ld_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            win_q    <= win_d;
            net_q    <= net_d;
            acq_q    <= acq_d;
            quiet_q  <= quiet_d;
            step_q   <= step_d;
            ld_q     <= ld_d;
            locked_q <= locked_d;
        end
    end

    assign o_step   = step_q;
    assign o_ld     = ld_q;
    assign o_locked = locked_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Bench for pll_loop_ctrl: directed scenarios plus randomized windows, with a
// window-level behavioural model checked against the DUT on every cycle.
module tb_pll_loop_ctrl;

    localparam longint SMAX = 64'h7FFF_FFFF;
    localparam longint SMIN = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [30:0] nom = '0;
    logic [1:0]  err = '0;
    logic [30:0] step;
    logic        ld, locked;
    logic [2:0]  st;

    int n_chk  = 0;
    int n_pass = 0;

    pll_loop_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_nom_step (nom),
        .i_err      (err),
        .o_step     (step),
        .o_ld       (ld),
        .o_locked   (locked),
        .o_state    (st)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle,1 load,2 acq,3 track,4 locked,5 update.
    int     m_state = 0, m_ret = 0, m_cnt = 0, m_net = 0, m_acq = 0, m_quiet = 0;
    int     m_ld = 0, m_locked = 0;
    longint m_step = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        longint nv;
        int     sh, mag;
        if (rst) begin
            m_state = 0; m_ret = 0; m_cnt = 0; m_net = 0; m_acq = 0; m_quiet = 0;
            m_step = 0; m_ld = 0; m_locked = 0;
            return;
        end
        m_ld = 0;
        if (!en) begin
            m_state = 0; m_locked = 0;
            return;
        end
        case (m_state)
            0: m_state = 1;
            1: begin
                m_step = nom; m_ld = 1; m_state = 2;
                m_cnt = 0; m_net = 0; m_acq = 0; m_quiet = 0;
            end
            2, 3, 4: begin
                if (err == 2'b01) m_net++;
                else if (err == 2'b11) m_net--;
                m_cnt++;
                if (m_cnt == 16) begin m_ret = m_state; m_state = 5; end
            end
            default: begin
                sh = (m_ret == 2) ? 8 : 4;
                nv = m_step + longint'(m_net) * (longint'(1) << sh);
                if (nv < SMIN) nv = SMIN;
                if (nv > SMAX) nv = SMAX;
                m_step = nv; m_ld = 1;
                mag = (m_net < 0) ? -m_net : m_net;
                m_net = 0; m_cnt = 0;
                case (m_ret)
                    2: begin m_acq++; m_state = (m_acq == 8) ? 3 : 2; end
                    3: begin
                        m_quiet = (mag <= 2) ? m_quiet + 1 : 0;
                        if (m_quiet == 4) begin m_state = 4; m_locked = 1; end
                        else m_state = 3;
                    end
                    default: begin
                        if (mag > 8) begin m_locked = 0; m_quiet = 0; m_state = 3; end
                        else m_state = 4;
                    end
                endcase
            end
        endcase
    endtask

    // Advance the model on every clock edge and on asynchronous reset.
    initial forever begin
        @(posedge clk or posedge rst);
        model_edge();
    end

    // Compare all outputs to the model mid-cycle.
    initial forever begin
        @(negedge clk);
        chk("step", step, m_step);
        chk("ld", ld, m_ld);
        chk("locked", locked, m_locked);
        chk("state", st, m_state);
    end

    // Error pattern: 0 none, 1 lag, 2 lead, 3 alternating, else random.
    task automatic drive(input int mode, input int i);
        case (mode)
            0: err = 2'b00;
            1: err = 2'b01;
            2: err = 2'b11;
            3: err = i[0] ? 2'b11 : 2'b01;
            default: err = 2'($urandom_range(0, 3));
        endcase
    endtask

    // Starts at the negedge of a load-strobe cycle; ends at the next strobe.
    task automatic win(input int mode, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            drive(mode, i);
            @(negedge clk);
            cyc++;
            if (ld) return;
        end
        chk("win_timeout", cyc, 17);
    endtask

    task automatic restart(input logic [30:0] n);
        en  = 1'b0;
        err = 2'b00;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        en  = 1'b1;
        nom = n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ld) return;
        end
        chk("load_timeout", 0, 1);
    endtask

    initial begin
        int c, a;
        #2;
        chk("rst_step", step, 0);
        chk("rst_ld", ld, 0);
        chk("rst_locked", locked, 0);
        chk("rst_state", st, 0);
        @(negedge clk);
        rst = 1'b0;

        restart(31'h0100_0000);
        chk("load_step", step, 31'h0100_0000);
        chk("load_state", st, 2);
        win(1, c);
        chk("acq_latency", c, 17);
        chk("acq_lag", step, 31'h0100_1000);
        win(2, c);
        chk("acq_lead1", step, 31'h0100_0000);
        win(2, c);
        chk("acq_lead2", step, 31'h00FF_F000);
        repeat (5) win(0, c);
        chk("to_track", st, 3);
        for (int k = 0; k < 4; k++) begin
            win(3, c);
            chk("lock_flag", locked, (k == 3));
        end
        chk("lock_state", st, 4);
        chk("lock_step", step, 31'h00FF_F000);
        win(2, c);
        chk("unlock_flag", locked, 0);
        chk("unlock_state", st, 3);
        chk("unlock_step", step, 31'h00FF_EF00);

        // Disable while sample 7 is on the input.
        for (int i = 0; i < 7; i++) begin drive(1, i); @(negedge clk); end
        en = 1'b0;
        err = 2'b01;
        @(negedge clk);
        chk("drop_state", st, 0);
        chk("drop_ld", ld, 0);
        chk("drop_step", step, 31'h00FF_EF00);
        repeat (3) @(negedge clk);
        chk("drop_hold", step, 31'h00FF_EF00);

        restart(31'h7FFF_FF00);
        chk("reload_step", step, 31'h7FFF_FF00);
        win(1, c);
        chk("clamp_max", step, 31'h7FFF_FFFF);
        restart(31'h0000_0001);
        win(2, c);
        chk("clamp_min", step, 1);

        for (int k = 0; k < 150; k++) begin
            a = $urandom_range(0, 9);
            if (a == 0) begin
                restart(($urandom_range(0, 1) == 1) ? 31'($urandom) : 31'($urandom_range(0, 4096)));
            end else if (a == 1) begin
                repeat ($urandom_range(0, 16)) begin drive(4, 0); @(negedge clk); end
                restart(31'($urandom));
            end else begin
                win($urandom_range(0, 4), c);
            end
        end

        // Reset between clock edges, landing on a load-strobe cycle.
        win(1, c);
        #2 rst = 1'b1;
        #1;
        chk("arst_step", step, 0);
        chk("arst_ld", ld, 0);
        chk("arst_locked", locked, 0);
        chk("arst_state", st, 0);
        @(negedge clk);
        rst = 1'b0;
        restart(31'h0012_3456);
        chk("post_rst_load", step, 31'h0012_3456);
        repeat (12) win($urandom_range(0, 4), c);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_loop_ctrl.md
Name: pll_loop_ctrl

Overview:
- Closed-loop frequency controller for the digital phase-tracking PLL (NCO counter plus phase detector).
- Consumes the detector's registered 2-bit error code, integrates it over fixed windows, and computes a new phase step. Writes the step back through the PLL's step/load port.
- Sequences the loop through load, acquisition (coarse gain), tracking (fine gain) and lock indication.

Parameters:
- PHASE_BITS, 32: NCO accumulator width; step width STEP_W = PHASE_BITS-1.
- INITIAL_STEP, 0: o_step value after reset.
- WINDOW_LEN, 16: error samples integrated per window (>=2).
- ACQ_WINDOWS, 8: windows spent in ACQUIRE before TRACK.
- ACQ_SHIFT, 8: left-shift applied to net error in ACQUIRE.
- TRK_SHIFT, 4: left-shift applied to net error in TRACK/LOCKED.
- STEP_MIN, 1: lower saturation bound for o_step.
- STEP_MAX, 2^(STEP_W)-1: upper saturation bound for o_step.
- LOCK_THRESH, 2: |net| at or below this counts as a quiet window.
- LOCK_COUNT, 4: consecutive quiet windows needed to declare lock.
- UNLOCK_THRESH, 8: |net| above this in LOCKED drops lock.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  loop enable; low forces IDLE.
- i_nom_step  in  STEP_W  nominal step loaded on enable.
- i_err  in  2  PLL error code: 00 none, 01 lag, 11 lead, 10 treated as none.
- o_step  out  STEP_W  step value to the PLL.
- o_ld  out  1  one-cycle load strobe; o_step is valid while o_ld is high.
- o_locked  out  1  lock indication.
- o_state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async, immediate): o_step=INITIAL_STEP, o_ld=0, o_locked=0, state=IDLE. Window counter, net accumulator, ACQ and quiet counters all cleared.
- States and encodings: IDLE=0, LOAD=1, ACQUIRE=2, TRACK=3, LOCKED=4, UPDATE=5.
  - UPDATE remembers its return mode: ACQUIRE, TRACK or LOCKED.
- IDLE: o_ld=0 and o_step is held. When i_en=1, go to LOAD.
- LOAD: one cycle. At exit edge, o_step<=i_nom_step and o_ld<=1. Go to ACQUIRE with counters cleared.
- Sampling (ACQUIRE/TRACK/LOCKED): each edge captures one i_err sample.
  - net += +1 on lag, -1 on lead.
  - net is signed, width clog2(WINDOW_LEN)+2.
  - The edge capturing sample WINDOW_LEN-1 moves the FSM to UPDATE.
- UPDATE: one cycle; i_err is ignored.
  - new = o_step + (net <<< shift), where shift = ACQ_SHIFT in ACQUIRE, otherwise TRK_SHIFT.
  - Computed signed in STEP_W+ACQ_SHIFT+clog2(WINDOW_LEN)+2 bits, then saturated to [STEP_MIN, STEP_MAX].
  - At exit edge, o_step<=new and o_ld<=1; net and window counter cleared.
  - Window period is therefore WINDOW_LEN+1 cycles.
- o_ld is high for exactly one cycle after each LOAD or UPDATE. It is also pulsed when the new value equals the old one.
- Mode transitions, evaluated at UPDATE exit:
  - ACQUIRE: increment ACQ counter. On reaching ACQ_WINDOWS, go to TRACK; otherwise stay in ACQUIRE.
  - TRACK: if |net|<=LOCK_THRESH, increment the quiet counter, else clear it. On reaching LOCK_COUNT, go to LOCKED and set o_locked=1.
  - LOCKED: if |net|>UNLOCK_THRESH, o_locked<=0, quiet counter cleared, go to TRACK. Otherwise stay LOCKED.
- i_en low in any non-IDLE state: next edge goes to IDLE.
  - o_locked<=0, o_ld<=0.
  - A pending update is discarded; o_step is not changed.
- i_en high again: always restarts via LOAD.
- Simultaneous events: i_en=0 has priority over UPDATE completion. i_rst overrides everything at any time, including mid-window and during an o_ld pulse (o_ld falls immediately).

Test Plan:
- Assert i_rst mid-operation -> o_step=INITIAL_STEP, o_ld=0, o_locked=0, o_state=0 without a clock edge.
- Enable with i_nom_step=0x0100_0000 -> one o_ld pulse, o_step=0x0100_0000, o_state=2.
- In ACQUIRE, 16 samples of 01 -> o_ld pulses 17 cycles after the LOAD pulse, o_step=0x0100_1000 (+16<<8). Same test with 16 samples of 11 -> 0x00FF_F000.
- STEP_MAX=0x0100_0800 with a full-lag window in ACQUIRE -> o_step clamps to 0x0100_0800. i_nom_step=1 with a full-lead window -> o_step=STEP_MIN=1.
- After 8 ACQUIRE windows, 4 windows of alternating 01/11 (net 0) -> o_locked=1 on the 4th update with o_step unchanged. Then a window of 16 leads -> o_locked=0, o_state=3, o_step -= 256.
- Drop i_en at sample 7 of a window -> IDLE next edge, no o_ld, o_step held. Re-enable -> LOAD pulse with the current i_nom_step.
